// File: rtl/pe_os_vec.sv
// Output-stationary systolic PE: LANES signed multipliers -> adder tree -> local accumulator.
// Latency: beat accepted at edge e; ifm_d after e, products after e+1, acc/res_q at e+2, res_valid_o the cycle after.
// Backpressure: a finished result waiting on res_ready_i stalls the whole datapath (in_ready=0).
//
// Ports: clk/rst (sync, active-high); operand stream in_valid/in_last/in_ready with packed
// ifm/wght (lane 0 in LSBs); forwarded copies ifm_d/wght_d/valid_d/last_d; drain chain
// res_*_i from upstream and res_*_o to downstream (ready/valid, res_last marks end of column).
// Optional macro PE_OS_VEC_SAT_EN: the accumulate add saturates instead of wrapping.
module pe_os_vec #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 24,
  parameter int LANES  = 4,
  parameter bit FIRST  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic [LANES*IWIDTH-1:0]   ifm,
  input  logic [LANES*IWIDTH-1:0]   wght,
  output logic [LANES*IWIDTH-1:0]   ifm_d,
  output logic [LANES*IWIDTH-1:0]   wght_d,
  output logic                      valid_d,
  output logic                      last_d,
  input  logic                      res_valid_i,
  input  logic                      res_last_i,
  input  logic [OWIDTH-1:0]         res_data_i,
  output logic                      res_ready_o,
  output logic                      res_valid_o,
  output logic                      res_last_o,
  output logic [OWIDTH-1:0]         res_data_o,
  input  logic                      res_ready_i
);

  localparam int PW = 2 * IWIDTH;
  localparam int SW = PW + $clog2(LANES);

  typedef enum logic [1:0] {IDLE, OWN, PASS} state_t;

  // S1: forwarded beat
  logic [LANES*IWIDTH-1:0] ifm_q, wght_q;
  logic                    valid_q, last_q;
  // S2: per-lane products
  logic signed [PW-1:0]    prod_q [LANES];
  logic                    v2_q, l2_q;
  // S3: accumulator and result holding register
  logic signed [OWIDTH-1:0] acc_q, acc_d, res_q, res_d;
  logic                     res_full_q, res_full_d;
  state_t                   state_q, state_d;

  logic signed [SW-1:0]     sum;
  logic signed [OWIDTH-1:0] sum_ext, add_res;
  logic                     leaving, stall;

  assign ifm_d   = ifm_q;
  assign wght_d  = wght_q;
  assign valid_d = valid_q;
  assign last_d  = last_q;

  // res_q frees up this cycle only if it is being handed downstream right now.
  assign leaving  = (state_q == OWN) && res_ready_i;
  assign stall    = v2_q && l2_q && res_full_q && !leaving;
  assign in_ready = !stall;

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SW'(prod_q[i]);
    end
    sum_ext = OWIDTH'(sum);
  end

`ifdef PE_OS_VEC_SAT_EN
  logic [OWIDTH:0] add_wide;
  always_comb begin
    add_wide = {acc_q[OWIDTH-1], acc_q} + {sum_ext[OWIDTH-1], sum_ext};
    // Top two bits disagree only on overflow; the guard bit carries the true sign.
    if (add_wide[OWIDTH] != add_wide[OWIDTH-1]) begin
      add_res = add_wide[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
    end else begin
      add_res = add_wide[OWIDTH-1:0];
    end
  end
`else
  assign add_res = acc_q + sum_ext;
`endif

  always_comb begin
    acc_d      = acc_q;
    res_d      = res_q;
    res_full_d = res_full_q;
    if (leaving) res_full_d = 1'b0;
    if (v2_q && !stall) begin
      if (l2_q) begin
        // Final beat: hand off and restart in the same edge so dot products can abut.
        res_d      = add_res;
        res_full_d = 1'b1;
        acc_d      = '0;
      end else begin
        acc_d = add_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifm_q      <= '0;
      wght_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      v2_q       <= 1'b0;
      l2_q       <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      res_full_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      if (!stall) begin
        ifm_q   <= ifm;
        wght_q  <= wght;
        valid_q <= in_valid;
        last_q  <= in_valid && in_last;
        v2_q    <= valid_q;
        l2_q    <= last_q;
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= PW'($signed(ifm_q[i*IWIDTH +: IWIDTH])) *
                       PW'($signed(wght_q[i*IWIDTH +: IWIDTH]));
        end
      end
      acc_q      <= acc_d;
      res_q      <= res_d;
      res_full_q <= res_full_d;
      state_q    <= state_d;
    end
  end

  // Drain FSM: emit own result, then (below the top) pass upstream beats through until end-of-column.
  always_comb begin
    state_d     = state_q;
    res_valid_o = 1'b0;
    res_last_o  = 1'b0;
    res_data_o  = res_q;
    res_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (res_full_q) state_d = OWN;
      end
      OWN: begin
        res_valid_o = 1'b1;
        res_last_o  = FIRST;
        if (res_ready_i) state_d = FIRST ? IDLE : PASS;
      end
      PASS: begin
        if (!FIRST) begin
          res_valid_o = res_valid_i;
          res_data_o  = res_data_i;
          res_last_o  = res_last_i;
          res_ready_o = res_ready_i;
          if (res_valid_i && res_ready_i && res_last_i) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/pe_os_vec.md
# pe_os_vec

Output-stationary systolic processing element: the next generation of the binary-parallel inner PE, generalised to `LANES` parallel signed multipliers feeding an adder tree and a local accumulator. Each PE forwards activations and weights to its neighbours one cycle later. It accumulates a dot product over a valid/last-framed stream. It then drains its result, followed by all upstream results, down a ready/valid column chain. It sits in the array fabric and replaces the single-lane PE where throughput per PE must scale.

## Interface
- `IWIDTH`, 8, signed operand width per lane
- `OWIDTH`, 24, signed accumulator/result width; must be ≥ 2·IWIDTH+clog2(LANES)
- `LANES`, 4, parallel multiplier lanes
- `FIRST`, 0, 1 = top PE of column (no upstream drain input used)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand beat valid
- `in_last`  in  1  final beat of current dot product
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `ifm`  in  LANES·IWIDTH  packed signed activations, lane 0 in LSBs
- `wght`  in  LANES·IWIDTH  packed signed weights
- `ifm_d`, `wght_d`  out  LANES·IWIDTH  registered forward copies
- `valid_d`, `last_d`  out  1  registered forward copies of accepted beat flags
- `res_valid_i`, `res_last_i`  in  1  upstream drain beat valid / end-of-column
- `res_data_i`  in  OWIDTH  upstream result
- `res_ready_o`  out  1  ready to upstream
- `res_valid_o`, `res_last_o`  out  1  drain beat valid / end-of-column
- `res_data_o`  out  OWIDTH  drain data
- `res_ready_i`  in  1  downstream ready

## Operation
- Three-stage datapath:
  - S1 registers the accepted beat (`ifm_d`, `wght_d`, `valid_d`, `last_d`).
  - S2 registers `LANES` products of width 2·IWIDTH.
  - S3 sign-extends the tree sum to OWIDTH and adds it to `acc`.
- S3 with a non-last beat: `acc <= acc + sum`.
- S3 with a last beat: `res_q <= acc + sum`, `res_full <= 1`, `acc <= 0` in the same edge, so back-to-back dot products need no bubble.
- Stall: a last beat in S3 while `res_full` is set and `res_q` is not leaving this cycle.
  - During a stall, S1/S2/S3 and `acc` hold, and `in_ready` = 0.
  - `in_ready = ~stall`, combinational from `res_ready_i`.
- While stalled, `valid_d` holds its value. Neighbours must sample `valid_d` only when `in_ready` is high.
- Drain FSM:
  - IDLE: `res_valid_o` = 0, `res_ready_o` = 0. Goes to OWN when `res_full`.
  - OWN: `res_valid_o` = 1, `res_data_o = res_q`, `res_last_o = FIRST`. On `res_ready_i`, clears `res_full`, then goes to IDLE if FIRST, else to PASS.
  - PASS: combinational pass-through. `res_valid_o = res_valid_i`, `res_data_o = res_data_i`, `res_last_o = res_last_i`, `res_ready_o = res_ready_i`. Returns to IDLE on an accepted beat with `res_last_i`.
- A new `res_q` may load during PASS; it drains on the next OWN.
- With FIRST = 1, the PE never enters PASS and `res_ready_o` is tied 0.

## Timing
- Reset: all pipeline registers, `acc`, `res_q`, `res_full`, `ifm_d`, `wght_d`, `valid_d`, `last_d` are 0 and FSM is IDLE. This gives `res_valid_o` = 0, `res_ready_o` = 0, `in_ready` = 1.
- Reset mid-operation discards any partial `acc` and any undrained `res_q`.
- Latency: beat accepted at edge e gives `ifm_d` valid after e, product after e+1, and `acc`/`res_q` update at e+2. For a last beat, `res_valid_o` rises in the cycle after e+2.
- One beat per cycle sustained while not stalled.
- Drain throughput is one result per cycle. The PASS path adds zero latency.

## Configuration
- `PE_OS_VEC_SAT_EN` defined: the S3 add (both accumulate and final) clamps to [−2^(OWIDTH−1), 2^(OWIDTH−1)−1].
- Not defined: two's-complement wrap at OWIDTH bits.

## Test plan
- All lanes ifm=3, wght=−2, two beats with `in_last` on the second → `res_data_o` = −48, `res_valid_o` high 3 cycles after the last beat is presented; FIRST=1 gives `res_last_o` = 1.
- All lanes ifm=−128, wght=−128, 128 beats, last on the 128th:
  - with `PE_OS_VEC_SAT_EN` → 0x7FFFFF;
  - without → 0x800000.
- Two back-to-back 1-beat dot products (values 1·1 and 2·2 on all lanes), `res_ready_i` = 0 → first result 4 held, `in_ready` drops when the second last beat reaches S3; raise `res_ready_i` → outputs 4 then 16, with no lost or duplicated beat.
- FIRST=0, own result 5, upstream presents 7 (last=0) then 9 (last=1) → downstream sees 5/0, 7/0, 9/1 and FSM returns to IDLE.
- Assert `rst` during PASS with a half-accumulated dot product → next cycle `res_valid_o` = 0, `res_ready_o` = 0, FSM IDLE; a fresh 1-beat product of 2·3 on all lanes yields 24.
- `ifm_d`/`wght_d` equal `ifm`/`wght` delayed exactly one accepted cycle, and `valid_d`/`last_d` track the same beats.
